// File: rtl/comp_writeback_ctrl_pkg.sv
// Shared state encodings, defaults and width helper for the completion write-back controller.
package comp_writeback_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_BACKOFF = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  localparam logic [7:0] DONE_CODE_DEF  = 8'hA5;
  localparam int         BACKOFF_CYCLES = 2;

  // Bits needed to count 0..n-1; never below 1 so degenerate configs still elaborate.
  function automatic int cnt_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comp_writeback_ctrl_if.sv
// Completion-queue pop and write-back bus bundle; master side is the controller.
interface comp_writeback_ctrl_if #(
  parameter int ADDRW = 24,
  parameter int DATAW = 8
);
  logic             cq_valid;
  logic             cq_ready;
  logic [ADDRW-1:0] cq_addr;
  logic             wb_req;
  logic [ADDRW-1:0] wb_addr;
  logic [DATAW-1:0] wb_data;
  logic             wb_ack;
  logic             wb_err;

  modport master (
    input  cq_valid, cq_addr, wb_ack, wb_err,
    output cq_ready, wb_req, wb_addr, wb_data
  );
  modport slave (
    output cq_valid, cq_addr, wb_ack, wb_err,
    input  cq_ready, wb_req, wb_addr, wb_data
  );
endinterface

// File: rtl/comp_writeback_ctrl_timer.sv
// Per-attempt timeout counter: saturates instead of wrapping, expires at TIMEOUT-1.
module wb_timeout_timer
  import comp_writeback_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expire
);
  localparam int TW = cnt_w(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (clear)                      cnt <= '0;
    else if (count && cnt != TW'(TIMEOUT)) cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/comp_writeback_ctrl.sv
// Drains completion addresses and writes DONE_CODE to each with timeout, retry and drop reporting.
// Define WB_STATS_EN to add saturating stat_done/stat_err counters.
module comp_writeback_ctrl
  import comp_writeback_ctrl_pkg::*;
#(
  parameter int               ADDRW     = 24,
  parameter int               DATAW     = 8,
  parameter logic [DATAW-1:0] DONE_CODE = DATAW'(DONE_CODE_DEF),
  parameter int               TIMEOUT   = 255,
  parameter int               MAX_RETRY = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  comp_writeback_ctrl_if.master bus,
  output logic                  busy,
  output logic                  err_pulse,
  output logic [ADDRW-1:0]      err_addr
`ifdef WB_STATS_EN
  ,
  output logic [15:0]           stat_done,
  output logic [15:0]           stat_err
`endif
);
  localparam int RW = cnt_w(MAX_RETRY + 1);
  localparam int BW = cnt_w(BACKOFF_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [ADDRW-1:0] addr_q;
  logic [RW-1:0]    retry_q;
  logic [BW-1:0]    bo_q;
  logic             cq_ready, accept, in_issue, expire, fail, can_retry;

  assign cq_ready  = (state_q == ST_IDLE) & enable;
  assign accept    = bus.cq_valid & cq_ready;
  assign in_issue  = (state_q == ST_ISSUE);
  // Ack takes priority over a same-cycle error or timeout.
  assign fail      = in_issue & ~bus.wb_ack & (bus.wb_err | expire);
  assign can_retry = retry_q < RW'(MAX_RETRY);

  wb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (~in_issue),
    .count  (in_issue & ~bus.wb_ack & ~bus.wb_err),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (bus.wb_ack) state_d = ST_DONE;
        else if (fail)  state_d = can_retry ? ST_BACKOFF : ST_ERR;
      end
      ST_BACKOFF: if (bo_q == BW'(BACKOFF_CYCLES - 1)) state_d = ST_ISSUE;
      ST_DONE:    state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      retry_q  <= '0;
      bo_q     <= '0;
      err_addr <= '0;
    end else begin
      state_q <= state_d;
      bo_q    <= (state_q == ST_BACKOFF) ? bo_q + 1'b1 : '0;
      if (accept) begin
        addr_q  <= bus.cq_addr;
        retry_q <= '0;
      end else if (fail && can_retry) begin
        retry_q <= retry_q + 1'b1;
      end
      // Loaded on the way into ERR so it is already valid alongside err_pulse.
      if (fail && !can_retry) err_addr <= addr_q;
    end
  end

  assign bus.cq_ready = cq_ready;
  assign bus.wb_req   = in_issue;
  assign bus.wb_addr  = addr_q;
  assign bus.wb_data  = in_issue ? DONE_CODE : '0;
  assign busy         = (state_q != ST_IDLE);
  assign err_pulse    = (state_q == ST_ERR);

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done <= '0;
      stat_err  <= '0;
    end else begin
      if (state_q == ST_DONE && stat_done != 16'hFFFF) stat_done <= stat_done + 1'b1;
      if (state_q == ST_ERR  && stat_err  != 16'hFFFF) stat_err  <= stat_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_comp_writeback_ctrl.sv
// Directed bench: default-timeout instance plus a TIMEOUT=8 instance for timeout/retry cases.
module tb_comp_writeback_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, enable, cq_valid, wb_ack, wb_err, sel;
  logic [23:0] cq_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  comp_writeback_ctrl_if #(.ADDRW(24), .DATAW(8)) if0 ();
  comp_writeback_ctrl_if #(.ADDRW(24), .DATAW(8)) if1 ();

  assign if0.cq_valid = cq_valid & ~sel;
  assign if1.cq_valid = cq_valid & sel;
  assign if0.cq_addr  = cq_addr;
  assign if1.cq_addr  = cq_addr;
  assign if0.wb_ack   = wb_ack & ~sel;
  assign if1.wb_ack   = wb_ack & sel;
  assign if0.wb_err   = wb_err & ~sel;
  assign if1.wb_err   = wb_err & sel;

  logic        busy0, busy1, errp0, errp1;
  logic [23:0] erra0, erra1;
`ifdef WB_STATS_EN
  logic [15:0] sd0, se0, sd1, se1;
`endif

  comp_writeback_ctrl #(.TIMEOUT(255), .MAX_RETRY(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(if0),
    .busy(busy0), .err_pulse(errp0), .err_addr(erra0)
`ifdef WB_STATS_EN
    , .stat_done(sd0), .stat_err(se0)
`endif
  );

  comp_writeback_ctrl #(.TIMEOUT(8), .MAX_RETRY(3)) u_dut_t8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(if1),
    .busy(busy1), .err_pulse(errp1), .err_addr(erra1)
`ifdef WB_STATS_EN
    , .stat_done(sd1), .stat_err(se1)
`endif
  );

  logic        r_cq_ready, r_wb_req, r_busy, r_err_pulse;
  logic [23:0] r_wb_addr, r_err_addr;
  logic [7:0]  r_wb_data;
  assign r_cq_ready  = sel ? if1.cq_ready : if0.cq_ready;
  assign r_wb_req    = sel ? if1.wb_req   : if0.wb_req;
  assign r_wb_addr   = sel ? if1.wb_addr  : if0.wb_addr;
  assign r_wb_data   = sel ? if1.wb_data  : if0.wb_data;
  assign r_busy      = sel ? busy1        : busy0;
  assign r_err_pulse = sel ? errp1        : errp0;
  assign r_err_addr  = sel ? erra1        : erra0;

  typedef struct {
    logic        sel;
    logic [23:0] addr;
    int          n_err;    // attempts answered with wb_err on their first cycle
    int          ack_dly;  // ISSUE cycle of the acking attempt that gets wb_ack, -1 = never
    logic        both;     // raise wb_err together with wb_ack
    logic        gap_ack;  // hold wb_ack high whenever wb_req is low
    int          exp_req, exp_att, exp_errp, exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          att, cyc, req_n, errp_n, bad, lat;
    logic        prev_req;
    logic [23:0] ea;
    string       tag;
    att = 0; cyc = 0; req_n = 0; errp_n = 0; bad = 0; lat = 0; prev_req = 1'b0; ea = '0;
    tag = $sformatf("v%0d", idx);
    sel = v.sel;
    @(negedge clk);
    check({tag, "_pre_ready"}, 32'(r_cq_ready), 32'd1);
    cq_valid = 1'b1;
    cq_addr  = v.addr;
    @(negedge clk);
    cq_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (r_cq_ready) begin lat = k; break; end
      if (r_err_pulse) begin errp_n++; ea = r_err_addr; end
      if (r_wb_req) begin
        if (!prev_req) begin att++; cyc = 0; end
        else cyc++;
        req_n++;
        if (r_wb_addr !== v.addr || r_wb_data !== 8'hA5) bad++;
        if (att <= v.n_err) wb_err = (cyc == 0);
        else if (cyc == v.ack_dly) begin wb_ack = 1'b1; wb_err = v.both; end
      end else if (v.gap_ack) begin
        wb_ack = 1'b1;
      end
      prev_req = r_wb_req;
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
    check({tag, "_req_cycles"}, 32'(req_n), 32'(v.exp_req));
    check({tag, "_attempts"},   32'(att),   32'(v.exp_att));
    check({tag, "_err_pulses"}, 32'(errp_n), 32'(v.exp_errp));
    check({tag, "_ready_lat"},  32'(lat),   32'(v.exp_lat));
    check({tag, "_addr_data"},  32'(bad),   32'd0);
    if (v.exp_errp != 0) begin
      check({tag, "_err_addr"},      32'(ea),         32'(v.addr));
      check({tag, "_err_addr_held"}, 32'(r_err_addr), 32'(v.addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_n, rdy_n, bad;
    //          sel  addr        nerr dly both gap  req att errp lat
    vecs[0] = '{1'b0, 24'h001234, 0,  0,  1'b0, 1'b0, 1,  1,  0,  3};
    vecs[1] = '{1'b0, 24'hABCDEF, 0,  10, 1'b0, 1'b0, 11, 1,  0,  13};
    vecs[2] = '{1'b1, 24'h00BEEF, 0,  -1, 1'b0, 1'b0, 32, 4,  1,  40};
    vecs[3] = '{1'b0, 24'h345678, 2,  0,  1'b0, 1'b0, 3,  3,  0,  9};
    vecs[4] = '{1'b0, 24'h0000FF, 0,  0,  1'b1, 1'b0, 1,  1,  0,  3};
    vecs[5] = '{1'b0, 24'h111111, 1,  0,  1'b0, 1'b1, 2,  2,  0,  6};
    vecs[6] = '{1'b0, 24'h222222, 4,  -1, 1'b0, 1'b0, 4,  4,  1,  12};
    vecs[7] = '{1'b1, 24'h333333, 0,  7,  1'b0, 1'b0, 8,  1,  0,  10};
    vecs[8] = '{1'b0, 24'hFFFFFF, 1,  3,  1'b0, 1'b0, 5,  2,  0,  9};

    rst_n = 1'b0; enable = 1'b1; cq_valid = 1'b0; cq_addr = '0;
    wb_ack = 1'b0; wb_err = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wb_req",    32'(r_wb_req),    32'd0);
    check("rst_wb_addr",   32'(r_wb_addr),   32'd0);
    check("rst_wb_data",   32'(r_wb_data),   32'd0);
    check("rst_busy",      32'(r_busy),      32'd0);
    check("rst_err_pulse", 32'(r_err_pulse), 32'd0);
    check("rst_err_addr",  32'(r_err_addr),  32'd0);
    check("rst_cq_ready",  32'(r_cq_ready),  32'd1);
    enable = 1'b0;
    #1 check("rst_ready_disabled", 32'(r_cq_ready), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

`ifdef WB_STATS_EN
    check("stat_done0", 32'(sd0), 32'd6);
    check("stat_err0",  32'(se0), 32'd1);
    check("stat_done1", 32'(sd1), 32'd1);
    check("stat_err1",  32'(se1), 32'd1);
`endif

    // enable drops during ISSUE while another entry waits in the queue
    sel = 1'b0;
    @(negedge clk);
    cq_valid = 1'b1; cq_addr = 24'h0A0A0A;
    @(negedge clk);
    check("en_req_start", 32'(r_wb_req), 32'd1);
    enable = 1'b0; cq_addr = 24'h0B0B0B;
    req_n = 0; rdy_n = 0; bad = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      wb_ack = (k == 3);
      if (r_wb_req) begin
        req_n++;
        if (r_wb_addr !== 24'h0A0A0A) bad++;
      end
      if (r_cq_ready) rdy_n++;
    end
    wb_ack = 1'b0;
    check("en_req_cycles", 32'(req_n), 32'd3);
    check("en_no_ready",   32'(rdy_n), 32'd0);
    check("en_addr",       32'(bad),   32'd0);
    check("en_idle_busy",  32'(r_busy), 32'd0);
    enable = 1'b1;
    #1 check("en_ready_back", 32'(r_cq_ready), 32'd1);
    @(negedge clk);
    cq_valid = 1'b0;
    check("en_next_req",  32'(r_wb_req),  32'd1);
    check("en_next_addr", 32'(r_wb_addr), 32'h0B0B0B);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check("en_next_drop", 32'(r_wb_req), 32'd0);
    @(negedge clk);
    check("en_next_idle", 32'(r_cq_ready), 32'd1);

    // asynchronous reset while a write is outstanding
    cq_valid = 1'b1; cq_addr = 24'h0C0C0C;
    @(negedge clk);
    cq_valid = 1'b0;
    check("rstmid_req", 32'(r_wb_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req_drop", 32'(r_wb_req),  32'd0);
    check("rstmid_busy",     32'(r_busy),    32'd0);
    check("rstmid_addr",     32'(r_wb_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (r_wb_req) req_n++;
    end
    check("rstmid_lost",  32'(req_n),      32'd0);
    check("rstmid_ready", 32'(r_cq_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
